run_sequencer: RTL
==================

Name: run_sequencer

Overview:
Run controller for the single-cycle miniMips core. It launches a program at a host-chosen PC and gates core execution with a clock-enable. It detects the halt instruction, enforces a watchdog cycle limit, and reports done or timeout. It also arbitrates the data-memory port between the host/bench (while the core is idle) and the core (while it runs).

Parameters:
PC_W, 8, program counter / data address width
INSTR_W, 9, instruction width
HALT_INSTR, 9'b101100100, encoding that terminates a program
CYC_W, 16, width of executed-instruction counter
TIMEOUT, 16'd4096, max instructions per run; 0 disables watchdog

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  run request, sampled at posedge
start_pc  in  PC_W  entry address, latched when start accepted
instr  in  INSTR_W  instruction currently fetched by core
core_en  out  1  core clock-enable: PC update, regfile and memory writes
pc_load  out  1  force core PC to pc_load_val this cycle
pc_load_val  out  PC_W  latched entry PC
mem_sel  out  1  1 = host owns data-memory port, 0 = core
host_req  in  1  host data-memory access request
host_gnt  out  1  grant, combinational: host_req & mem_sel
busy  out  1  high in LOAD and RUN
done  out  1  program halted normally
timeout  out  1  watchdog expired
cycle_count  out  CYC_W  instructions executed in current/last run

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, core_en 0, pc_load 0, pc_load_val 0, mem_sel 1, busy 0, done 0, timeout 0, cycle_count 0. Reset mid-run aborts immediately with no drain.
- Registered FSM states: IDLE, LOAD, RUN, DONE, FAULT.
- IDLE: core_en 0, mem_sel 1. start=1 -> latch start_pc, clear cycle_count, go to LOAD.
- LOAD (exactly 1 cycle):
  - pc_load 1, core_en 0, mem_sel 0, busy 1; go to RUN.
  - Core PC equals start_pc at the start of the first RUN cycle.
- RUN: mem_sel 0, busy 1.
  - core_en = (instr != HALT_INSTR), combinational, so the halt instruction never updates PC or state.
  - Each RUN cycle with core_en=1: cycle_count += 1.
  - instr == HALT_INSTR -> DONE.
  - Else if TIMEOUT != 0 and cycle_count == TIMEOUT-1: that instruction executes (count reaches TIMEOUT), then go to FAULT.
  - Halt takes priority over watchdog in the same cycle.
- DONE: done 1, core_en 0, mem_sel 1 so the host can read results. cycle_count holds.
- FAULT: timeout 1, done 0, core_en 0, mem_sel 1. cycle_count holds at TIMEOUT.
- From DONE or FAULT: start=1 -> clear done/timeout/cycle_count, latch new start_pc, go to LOAD. Flags drop the cycle after start is sampled.
- start is ignored in LOAD and RUN. start_pc is sampled only when start is accepted.
- Host arbitration:
  - host_gnt is never 1 while mem_sel=0.
  - A host request during LOAD/RUN stalls (gnt 0) and the host must hold host_req.
  - Grant appears combinationally in the first DONE/FAULT/IDLE cycle.
- Latency: start sampled at edge N -> LOAD during cycle N+1 -> first instruction executes in cycle N+2.
- cycle_count is never incremented outside RUN. No wrap: the watchdog fires first when TIMEOUT != 0. With TIMEOUT=0 it wraps modulo 2^CYC_W.

Test Plan:
1. Normal run: start=1, start_pc=0x10; program has 4 instructions then halt at 0x14 -> pc_load=1 one cycle, core_en=1 for 4 cycles, done=1, cycle_count=4, core_en=0 on the halt cycle.
2. Immediate halt: HALT_INSTR at start_pc -> DONE after 1 RUN cycle, cycle_count=0, no core writes.
3. Watchdog: TIMEOUT=8, infinite loop -> exactly 8 core_en cycles, timeout=1, done=0, cycle_count=8. Also halt arriving on the 8th cycle -> done=1, timeout=0.
4. Arbitration: host_req held in IDLE -> host_gnt=1. Start a run with host_req=1 -> gnt=0 through LOAD/RUN, gnt=1 in the first DONE cycle.
5. Restart and ignored start: start pulsed during RUN has no effect. start in DONE with start_pc=0x40 -> done drops next cycle, LOAD loads 0x40, cycle_count restarts from 0.
6. Async reset asserted mid-RUN between clock edges -> all outputs immediately at reset values, state IDLE; after release a normal start works.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: launches a miniMips program at a host-chosen PC, gates the
// core with a clock-enable, stops on the halt instruction or on the watchdog
// limit, and hands the data-memory port to the host whenever the core is idle.
//
// Handshake: start is a level request sampled at posedge clk and is accepted
// only in IDLE, DONE or FAULT. host_req must be held until host_gnt is seen
// high. host_gnt is combinational (host_req & mem_sel), so the grant appears
// in the same cycle that the port becomes free.
module run_sequencer #(
  parameter int                     PC_W       = 8,
  parameter int                     INSTR_W    = 9,
  parameter logic [INSTR_W-1:0]     HALT_INSTR = 9'b101100100,
  parameter int                     CYC_W      = 16,
  parameter logic [CYC_W-1:0]       TIMEOUT    = 16'd4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               core_en,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               mem_sel,
  input  logic               host_req,
  output logic               host_gnt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycle_count,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  // Count value at which the next executed instruction is the last allowed.
  localparam logic [CYC_W-1:0] WD_LAST = TIMEOUT - CYC_ONE;
  localparam logic             WD_ON   = (TIMEOUT != '0);

  state_t state, state_nx;
  logic   accept;      // start taken this cycle
  logic   count_inc;   // an instruction executes this cycle

  // State register; reset aborts any run immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and all control outputs, decoded from the current state.
  always_comb begin
    state_nx  = state;
    core_en   = 1'b0;
    pc_load   = 1'b0;
    mem_sel   = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    accept    = 1'b0;
    count_inc = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        done    = (state == S_DONE);
        timeout = (state == S_FAULT);
        if (start) begin
          accept   = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_load  = 1'b1;
        mem_sel  = 1'b0;
        busy     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        mem_sel = 1'b0;
        busy    = 1'b1;
        // The halt instruction itself must never update PC or core state.
        core_en = (instr != HALT_INSTR);
        if (!core_en) begin
          state_nx = S_DONE;
        end else begin
          count_inc = 1'b1;
          if (WD_ON && (cycle_count == WD_LAST)) state_nx = S_FAULT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Entry PC latch and executed-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_load_val <= '0;
      cycle_count <= '0;
    end else if (accept) begin
      pc_load_val <= start_pc;
      cycle_count <= '0;
    end else if (count_inc) begin
      cycle_count <= cycle_count + CYC_ONE;
    end
  end

  assign host_gnt  = host_req & mem_sel;
  assign state_dbg = state;

endmodule
